// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//   Shares one external SRAM bank between a read-only icache port and a
//   read/write dcache port. Every access runs IDLE -> ACCESS (WAIT_CYCLES
//   cycles) -> DONE (1 cycle) -> IDLE. Dcache normally wins arbitration. A
//   starvation counter forces an icache grant after STARVE_LIMIT consecutive
//   dcache grants that were made while icache was waiting.
//
// Parameters
//   WAIT_CYCLES   cycles the address/control are driven before read data is
//                 sampled (1..7)
//   STARVE_LIMIT  dcache grants with icache pending before icache is forced
//                 (1..15)
//
// Ports
//   clk, rst_n                       clock, synchronous active-low reset
//   icache_req/addr                  icache read request (held until done)
//   icache_rdata/done                icache read data (held) and done pulse
//   dcache_req/we/addr/wdata/be_n    dcache request (held until done)
//   dcache_rdata/done                dcache read data (held) and done pulse
//   ram_data_in                      SRAM read data
//   ram_data_out/addr/be_n/we        SRAM write data, address, active-low
//                                    byte enables, active-high write enable
// ---------------------------------------------------------------------------
module sram_arbiter #(
   parameter int unsigned WAIT_CYCLES  = 1,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        icache_req,
   input  logic [31:0] icache_addr,
   output logic [31:0] icache_rdata,
   output logic        icache_done,
   input  logic        dcache_req,
   input  logic        dcache_we,
   input  logic [31:0] dcache_addr,
   input  logic [31:0] dcache_wdata,
   input  logic [3:0]  dcache_be_n,
   output logic [31:0] dcache_rdata,
   output logic        dcache_done,
   input  logic [31:0] ram_data_in,
   output logic [31:0] ram_data_out,
   output logic [31:0] ram_addr,
   output logic [3:0]  ram_be_n,
   output logic        ram_we
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic [2:0] WAIT_LOAD  = 3'(WAIT_CYCLES);
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   state_t      state_q, state_d;
   logic        gnt_dc_q, gnt_dc_d;      // 1 = current transaction belongs to dcache
   logic        wr_q, wr_d;              // current transaction is a write
   logic [2:0]  wait_cnt_q, wait_cnt_d;
   logic [3:0]  starve_cnt_q, starve_cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_n_q, be_n_d;
   logic [31:0] irdata_q, irdata_d;
   logic [31:0] drdata_q, drdata_d;
   logic        grant_ic;

   always_comb begin
      state_d      = state_q;
      gnt_dc_d     = gnt_dc_q;
      wr_d         = wr_q;
      wait_cnt_d   = wait_cnt_q;
      starve_cnt_d = starve_cnt_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      be_n_d       = be_n_q;
      irdata_d     = irdata_q;
      drdata_d     = drdata_q;
      grant_ic     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Icache only wins when dcache is absent or icache has waited long enough.
            grant_ic = icache_req && (!dcache_req || (starve_cnt_q == STARVE_MAX));

            // The counter only survives dcache grants made while icache waits.
            if (grant_ic || !icache_req) begin
               starve_cnt_d = 4'd0;
            end else if (dcache_req && (starve_cnt_q != 4'hF)) begin
               starve_cnt_d = starve_cnt_q + 4'd1;
            end

            if (icache_req || dcache_req) begin
               state_d    = ST_ACCESS;
               wait_cnt_d = WAIT_LOAD;
               gnt_dc_d   = !grant_ic;
               wr_d       = !grant_ic && dcache_we;
               addr_d     = grant_ic ? icache_addr : dcache_addr;
               if (!grant_ic) begin
                  wdata_d = dcache_wdata;
               end
               // Reads enable every byte lane; writes use the requester's mask.
               be_n_d = (!grant_ic && dcache_we) ? dcache_be_n : 4'h0;
            end else begin
               be_n_d = 4'hF;
            end
         end

         ST_ACCESS: begin
            wait_cnt_d = wait_cnt_q - 3'd1;
            if (wait_cnt_q == 3'd1) begin
               state_d = ST_DONE;
               if (!wr_q) begin
                  if (gnt_dc_q) begin
                     drdata_d = ram_data_in;
                  end else begin
                     irdata_d = ram_data_in;
                  end
               end
            end
         end

         ST_DONE: begin
            // Address and byte enables stay put through DONE so a write sees
            // address hold after ram_we falls; lanes are released afterwards.
            state_d = ST_IDLE;
            be_n_d  = 4'hF;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         gnt_dc_q     <= 1'b0;
         wr_q         <= 1'b0;
         wait_cnt_q   <= 3'd0;
         starve_cnt_q <= 4'd0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         be_n_q       <= 4'hF;
         irdata_q     <= 32'd0;
         drdata_q     <= 32'd0;
      end else begin
         state_q      <= state_d;
         gnt_dc_q     <= gnt_dc_d;
         wr_q         <= wr_d;
         wait_cnt_q   <= wait_cnt_d;
         starve_cnt_q <= starve_cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         be_n_q       <= be_n_d;
         irdata_q     <= irdata_d;
         drdata_q     <= drdata_d;
      end
   end

   // Write enable is derived from the state so it can never leak outside ACCESS.
   assign ram_we       = (state_q == ST_ACCESS) && wr_q;
   assign ram_addr     = addr_q;
   assign ram_data_out = wdata_q;
   assign ram_be_n     = be_n_q;
   assign icache_done  = (state_q == ST_DONE) && !gnt_dc_q;
   assign dcache_done  = (state_q == ST_DONE) && gnt_dc_q;
   assign icache_rdata = irdata_q;
   assign dcache_rdata = drdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
//   Two arbiter instances: index 0 with WAIT_CYCLES=1, index 1 with
//   WAIT_CYCLES=3, both with STARVE_LIMIT=4. Directed vectors and sequences
//   first, then randomized traffic compared against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;

   localparam int W0 = 1;
   localparam int W1 = 3;
   localparam int SL = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n        [2];
   logic        icache_req   [2];
   logic [31:0] icache_addr  [2];
   logic [31:0] icache_rdata [2];
   logic        icache_done  [2];
   logic        dcache_req   [2];
   logic        dcache_we    [2];
   logic [31:0] dcache_addr  [2];
   logic [31:0] dcache_wdata [2];
   logic [3:0]  dcache_be_n  [2];
   logic [31:0] dcache_rdata [2];
   logic        dcache_done  [2];
   logic [31:0] ram_data_in  [2];
   logic [31:0] ram_data_out [2];
   logic [31:0] ram_addr     [2];
   logic [3:0]  ram_be_n     [2];
   logic        ram_we       [2];

   sram_arbiter #(.WAIT_CYCLES(W0), .STARVE_LIMIT(SL)) u_w1 (
      .clk(clk), .rst_n(rst_n[0]),
      .icache_req(icache_req[0]), .icache_addr(icache_addr[0]),
      .icache_rdata(icache_rdata[0]), .icache_done(icache_done[0]),
      .dcache_req(dcache_req[0]), .dcache_we(dcache_we[0]),
      .dcache_addr(dcache_addr[0]), .dcache_wdata(dcache_wdata[0]),
      .dcache_be_n(dcache_be_n[0]), .dcache_rdata(dcache_rdata[0]),
      .dcache_done(dcache_done[0]), .ram_data_in(ram_data_in[0]),
      .ram_data_out(ram_data_out[0]), .ram_addr(ram_addr[0]),
      .ram_be_n(ram_be_n[0]), .ram_we(ram_we[0])
   );

   sram_arbiter #(.WAIT_CYCLES(W1), .STARVE_LIMIT(SL)) u_w3 (
      .clk(clk), .rst_n(rst_n[1]),
      .icache_req(icache_req[1]), .icache_addr(icache_addr[1]),
      .icache_rdata(icache_rdata[1]), .icache_done(icache_done[1]),
      .dcache_req(dcache_req[1]), .dcache_we(dcache_we[1]),
      .dcache_addr(dcache_addr[1]), .dcache_wdata(dcache_wdata[1]),
      .dcache_be_n(dcache_be_n[1]), .dcache_rdata(dcache_rdata[1]),
      .dcache_done(dcache_done[1]), .ram_data_in(ram_data_in[1]),
      .ram_data_out(ram_data_out[1]), .ram_addr(ram_addr[1]),
      .ram_be_n(ram_be_n[1]), .ram_we(ram_we[1])
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", nm, act, exp);
      end
   endtask

   function automatic int wc(input int u);
      return (u == 0) ? W0 : W1;
   endfunction

   task automatic clr_in(input int u);
      icache_req[u]   = 1'b0;
      icache_addr[u]  = 32'd0;
      dcache_req[u]   = 1'b0;
      dcache_we[u]    = 1'b0;
      dcache_addr[u]  = 32'd0;
      dcache_wdata[u] = 32'd0;
      dcache_be_n[u]  = 4'hF;
      ram_data_in[u]  = 32'd0;
   endtask

   task automatic chk_reset(input int u, input string tag);
      chk1 ($sformatf("%s u%0d icache_done", tag, u), icache_done[u], 1'b0);
      chk1 ($sformatf("%s u%0d dcache_done", tag, u), dcache_done[u], 1'b0);
      chk32($sformatf("%s u%0d icache_rdata", tag, u), icache_rdata[u], 32'd0);
      chk32($sformatf("%s u%0d dcache_rdata", tag, u), dcache_rdata[u], 32'd0);
      chk1 ($sformatf("%s u%0d ram_we", tag, u), ram_we[u], 1'b0);
      chk32($sformatf("%s u%0d ram_addr", tag, u), ram_addr[u], 32'd0);
      chk32($sformatf("%s u%0d ram_data_out", tag, u), ram_data_out[u], 32'd0);
      chk4 ($sformatf("%s u%0d ram_be_n", tag, u), ram_be_n[u], 4'hF);
   endtask

   // ---------------- directed single-transaction vectors (instance 0) -------
   typedef struct {
      logic        dsel;     // 1 = dcache request, 0 = icache request
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be_n;
      logic [31:0] ram_in;
      logic [3:0]  exp_be;
      logic        exp_we;
      logic [31:0] exp_ir;
      logic [31:0] exp_dr;
   } vec_t;

   vec_t vt [6];

   task automatic apply_vec(input int idx, input vec_t v);
      string t;
      t = $sformatf("vec%0d", idx);
      if (v.dsel) begin
         dcache_req[0]   = 1'b1;
         dcache_we[0]    = v.we;
         dcache_addr[0]  = v.addr;
         dcache_wdata[0] = v.wdata;
         dcache_be_n[0]  = v.be_n;
      end else begin
         icache_req[0]  = 1'b1;
         icache_addr[0] = v.addr;
      end
      ram_data_in[0] = v.ram_in;
      @(negedge clk);
      chk32({t, " access ram_addr"}, ram_addr[0], v.addr);
      chk1 ({t, " access ram_we"}, ram_we[0], v.exp_we);
      chk4 ({t, " access ram_be_n"}, ram_be_n[0], v.exp_be);
      if (v.we) chk32({t, " access ram_data_out"}, ram_data_out[0], v.wdata);
      chk1 ({t, " access icache_done"}, icache_done[0], 1'b0);
      chk1 ({t, " access dcache_done"}, dcache_done[0], 1'b0);
      @(negedge clk);
      chk1 ({t, " done icache_done"}, icache_done[0], !v.dsel);
      chk1 ({t, " done dcache_done"}, dcache_done[0], v.dsel);
      chk1 ({t, " done ram_we"}, ram_we[0], 1'b0);
      chk32({t, " done ram_addr held"}, ram_addr[0], v.addr);
      chk4 ({t, " done ram_be_n held"}, ram_be_n[0], v.exp_be);
      chk32({t, " done icache_rdata"}, icache_rdata[0], v.exp_ir);
      chk32({t, " done dcache_rdata"}, dcache_rdata[0], v.exp_dr);
      icache_req[0]  = 1'b0;
      dcache_req[0]  = 1'b0;
      ram_data_in[0] = 32'h0BAD_0BAD;
      @(negedge clk);
      chk1 ({t, " idle icache_done"}, icache_done[0], 1'b0);
      chk1 ({t, " idle dcache_done"}, dcache_done[0], 1'b0);
      chk1 ({t, " idle ram_we"}, ram_we[0], 1'b0);
      chk4 ({t, " idle ram_be_n"}, ram_be_n[0], 4'hF);
      chk32({t, " idle icache_rdata held"}, icache_rdata[0], v.exp_ir);
      chk32({t, " idle dcache_rdata held"}, dcache_rdata[0], v.exp_dr);
   endtask

   // ---------------- transaction-level reference model ----------------------
   bit          m_busy  [2];
   int          m_phase [2];   // cycles since the grant while busy
   bit          m_dsel  [2];
   bit          m_we    [2];
   logic [31:0] m_addr  [2];
   logic [31:0] m_wdata [2];
   logic [3:0]  m_be    [2];
   int          m_starve[2];
   logic [31:0] e_ir    [2];
   logic [31:0] e_dr    [2];
   logic [31:0] e_addr  [2];
   logic [3:0]  e_be    [2];
   bit          e_we    [2];
   bit          e_idone [2];
   bit          e_ddone [2];
   bit          e_addr_v[2];
   bit          e_wd_v  [2];

   task automatic model_reset(input int u);
      m_busy[u]   = 1'b0;
      m_phase[u]  = 0;
      m_starve[u] = 0;
      e_ir[u]     = 32'd0;
      e_dr[u]     = 32'd0;
      e_addr[u]   = 32'd0;
      e_be[u]     = 4'hF;
      e_we[u]     = 1'b0;
      e_idone[u]  = 1'b0;
      e_ddone[u]  = 1'b0;
      e_addr_v[u] = 1'b1;
      e_wd_v[u]   = 1'b0;
   endtask

   // Uses the inputs presented this cycle to predict the outputs of the next.
   task automatic model_step(input int u);
      bit give_i;
      if (!rst_n[u]) begin
         model_reset(u);
         return;
      end
      e_idone[u] = 1'b0;
      e_ddone[u] = 1'b0;
      e_wd_v[u]  = 1'b0;
      if (!m_busy[u]) begin
         if (icache_req[u] || dcache_req[u]) begin
            give_i = icache_req[u] && (!dcache_req[u] || (m_starve[u] == SL));
            if (give_i || !icache_req[u]) m_starve[u] = 0;
            else if (m_starve[u] < 15)    m_starve[u] = m_starve[u] + 1;
            m_busy[u]  = 1'b1;
            m_phase[u] = 1;
            m_dsel[u]  = !give_i;
            m_we[u]    = !give_i && dcache_we[u];
            m_addr[u]  = give_i ? icache_addr[u] : dcache_addr[u];
            m_wdata[u] = dcache_wdata[u];
            m_be[u]    = m_we[u] ? dcache_be_n[u] : 4'h0;
            e_we[u]     = m_we[u];
            e_be[u]     = m_be[u];
            e_addr[u]   = m_addr[u];
            e_addr_v[u] = 1'b1;
            e_wd_v[u]   = m_we[u];
         end else begin
            m_starve[u] = 0;
            e_we[u]     = 1'b0;
            e_be[u]     = 4'hF;
            e_addr_v[u] = 1'b0;
         end
      end else if (m_phase[u] <= wc(u)) begin
         if ((m_phase[u] == wc(u)) && !m_we[u]) begin
            if (m_dsel[u]) e_dr[u] = ram_data_in[u];
            else           e_ir[u] = ram_data_in[u];
         end
         m_phase[u] = m_phase[u] + 1;
         if (m_phase[u] == wc(u) + 1) begin
            e_we[u]    = 1'b0;
            e_idone[u] = !m_dsel[u];
            e_ddone[u] = m_dsel[u];
         end else begin
            e_wd_v[u] = m_we[u];
         end
      end else begin
         m_busy[u]   = 1'b0;
         e_we[u]     = 1'b0;
         e_be[u]     = 4'hF;
         e_addr_v[u] = 1'b0;
      end
   endtask

   task automatic model_check(input int u, input int cyc);
      string t;
      t = $sformatf("rand u%0d c%0d", u, cyc);
      chk1 ({t, " icache_done"}, icache_done[u], e_idone[u]);
      chk1 ({t, " dcache_done"}, dcache_done[u], e_ddone[u]);
      chk32({t, " icache_rdata"}, icache_rdata[u], e_ir[u]);
      chk32({t, " dcache_rdata"}, dcache_rdata[u], e_dr[u]);
      chk1 ({t, " ram_we"}, ram_we[u], e_we[u]);
      chk4 ({t, " ram_be_n"}, ram_be_n[u], e_be[u]);
      if (e_addr_v[u]) chk32({t, " ram_addr"}, ram_addr[u], e_addr[u]);
      if (e_wd_v[u])   chk32({t, " ram_data_out"}, ram_data_out[u], m_wdata[u]);
   endtask

   task automatic drive_rand(input int u);
      if (!rst_n[u])                        rst_n[u] = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst_n[u] = 1'b0;
      ram_data_in[u] = $urandom;
      if (e_idone[u]) begin
         icache_req[u]  = ($urandom_range(0, 2) == 0);
         icache_addr[u] = $urandom;
      end else if (icache_req[u]) begin
         if ($urandom_range(0, 39) == 0) icache_req[u] = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
         icache_req[u]  = 1'b1;
         icache_addr[u] = $urandom;
      end
      if (e_ddone[u] || (!dcache_req[u] && ($urandom_range(0, 1) == 0))) begin
         dcache_req[u]   = e_ddone[u] ? ($urandom_range(0, 2) != 0) : 1'b1;
         dcache_we[u]    = 1'($urandom);
         dcache_addr[u]  = $urandom;
         dcache_wdata[u] = $urandom;
         dcache_be_n[u]  = 4'($urandom);
      end else if (dcache_req[u] && ($urandom_range(0, 39) == 0)) begin
         dcache_req[u] = 1'b0;
      end
   endtask

   // ---------------- main sequence ------------------------------------------
   initial begin
      int   d_cyc, i_cyc, overlap, n_seq;
      logic seq [10];
      logic exp_seq [10];

      vt[0] = '{dsel:1'b0, we:1'b0, addr:32'h8000_0010, wdata:32'h0, be_n:4'hF,
                ram_in:32'h2408_0001, exp_be:4'h0, exp_we:1'b0,
                exp_ir:32'h2408_0001, exp_dr:32'h0};
      vt[1] = '{dsel:1'b1, we:1'b1, addr:32'h8040_0004, wdata:32'hDEAD_BEEF, be_n:4'b1100,
                ram_in:32'hFFFF_0000, exp_be:4'b1100, exp_we:1'b1,
                exp_ir:32'h2408_0001, exp_dr:32'h0};
      vt[2] = '{dsel:1'b1, we:1'b0, addr:32'h8040_0008, wdata:32'h1111_1111, be_n:4'h5,
                ram_in:32'hCAFE_F00D, exp_be:4'h0, exp_we:1'b0,
                exp_ir:32'h2408_0001, exp_dr:32'hCAFE_F00D};
      vt[3] = '{dsel:1'b1, we:1'b1, addr:32'h0000_0100, wdata:32'h0123_4567, be_n:4'h0,
                ram_in:32'h7777_7777, exp_be:4'h0, exp_we:1'b1,
                exp_ir:32'h2408_0001, exp_dr:32'hCAFE_F00D};
      vt[4] = '{dsel:1'b0, we:1'b0, addr:32'hFFFF_FFFC, wdata:32'h0, be_n:4'hF,
                ram_in:32'h5555_AAAA, exp_be:4'h0, exp_we:1'b0,
                exp_ir:32'h5555_AAAA, exp_dr:32'hCAFE_F00D};
      vt[5] = '{dsel:1'b1, we:1'b1, addr:32'h8000_0000, wdata:32'hFFFF_FFFF, be_n:4'b1110,
                ram_in:32'h0, exp_be:4'b1110, exp_we:1'b1,
                exp_ir:32'h5555_AAAA, exp_dr:32'hCAFE_F00D};
      exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      for (int u = 0; u < 2; u++) begin
         clr_in(u);
         rst_n[u] = 1'b0;
      end
      @(negedge clk);
      @(negedge clk);
      chk_reset(0, "reset");
      chk_reset(1, "reset");
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) apply_vec(i, vt[i]);

      // Simultaneous requests: dcache first, icache right after.
      icache_req[0]  = 1'b1;  icache_addr[0] = 32'h8000_0100;
      dcache_req[0]  = 1'b1;  dcache_we[0]   = 1'b0;
      dcache_addr[0] = 32'h8040_0100;
      d_cyc = -1; i_cyc = -1; overlap = 0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (icache_done[0] && dcache_done[0]) overlap++;
         if (dcache_done[0] && d_cyc < 0) begin d_cyc = c; dcache_req[0] = 1'b0; end
         if (icache_done[0] && i_cyc < 0) begin i_cyc = c; icache_req[0] = 1'b0; end
      end
      chk32("both-req dcache_done cycle", 32'(d_cyc), 32'd2);
      chk32("both-req icache_done cycle", 32'(i_cyc), 32'd5);
      chk32("both-req done overlap count", 32'(overlap), 32'd0);

      // Starvation: both requesters re-present after every completion.
      icache_req[0] = 1'b1;
      dcache_req[0] = 1'b1;
      n_seq = 0;
      for (int c = 0; c < 60 && n_seq < 10; c++) begin
         @(negedge clk);
         if (icache_done[0] && dcache_done[0]) overlap++;
         if (dcache_done[0]) begin seq[n_seq] = 1'b1; n_seq++; dcache_addr[0] = dcache_addr[0] + 32'd4; end
         else if (icache_done[0]) begin seq[n_seq] = 1'b0; n_seq++; icache_addr[0] = icache_addr[0] + 32'd4; end
      end
      icache_req[0] = 1'b0;
      dcache_req[0] = 1'b0;
      chk32("starve grant count", 32'(n_seq), 32'd10);
      for (int k = 0; k < n_seq; k++)
         chk1($sformatf("starve grant %0d is dcache", k), seq[k], exp_seq[k]);
      chk32("starve done overlap count", 32'(overlap), 32'd0);
      @(negedge clk);
      @(negedge clk);

      // Reset in the middle of a WAIT_CYCLES=3 write.
      dcache_req[1]   = 1'b1;  dcache_we[1]   = 1'b1;
      dcache_addr[1]  = 32'h8040_0020;
      dcache_wdata[1] = 32'hA5A5_5A5A;
      dcache_be_n[1]  = 4'b0011;
      @(negedge clk);
      chk1 ("midrst access1 ram_we", ram_we[1], 1'b1);
      chk4 ("midrst access1 ram_be_n", ram_be_n[1], 4'b0011);
      @(negedge clk);
      chk1 ("midrst access2 ram_we", ram_we[1], 1'b1);
      rst_n[1] = 1'b0;
      @(negedge clk);
      chk_reset(1, "midrst");
      rst_n[1]      = 1'b1;
      dcache_req[1] = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk1($sformatf("midrst after%0d dcache_done", c), dcache_done[1], 1'b0);
         chk1($sformatf("midrst after%0d ram_we", c), ram_we[1], 1'b0);
      end

      // WAIT_CYCLES=3 dcache read.
      dcache_req[1]  = 1'b1;  dcache_we[1] = 1'b0;
      dcache_addr[1] = 32'h8040_0000;
      ram_data_in[1] = 32'h1234_5678;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         chk32($sformatf("w3 read c%0d ram_addr", c), ram_addr[1], 32'h8040_0000);
         chk4 ($sformatf("w3 read c%0d ram_be_n", c), ram_be_n[1], 4'h0);
         chk1 ($sformatf("w3 read c%0d ram_we", c), ram_we[1], 1'b0);
         chk1 ($sformatf("w3 read c%0d dcache_done", c), dcache_done[1], 1'b0);
      end
      @(negedge clk);
      chk1 ("w3 read c4 dcache_done", dcache_done[1], 1'b1);
      chk1 ("w3 read c4 icache_done", icache_done[1], 1'b0);
      chk32("w3 read c4 dcache_rdata", dcache_rdata[1], 32'h1234_5678);
      dcache_req[1] = 1'b0;
      @(negedge clk);
      chk1 ("w3 read c5 dcache_done", dcache_done[1], 1'b0);

      // Randomized traffic on both instances against the model.
      for (int u = 0; u < 2; u++) begin
         clr_in(u);
         rst_n[u] = 1'b0;
      end
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         model_reset(u);
         rst_n[u] = 1'b1;
      end
      for (int c = 0; c < 3000; c++) begin
         for (int u = 0; u < 2; u++) begin
            model_check(u, c);
            drive_rand(u);
            model_step(u);
         end
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
